// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions for the pipeline hazard controller: opcode/funct
// constants, timing encodings and a per-stage instruction decode function.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // Cycles until a result exists (measured from E) / until an operand is needed (from D).
  typedef enum logic [1:0] {TNEW_0 = 2'd0, TNEW_1 = 2'd1, TNEW_2 = 2'd2} tnew_t;
  typedef enum logic [1:0] {TUSE_0 = 2'd0, TUSE_1 = 2'd1, TUSE_2 = 2'd2} tuse_t;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_M = 2'd1, FWD_W = 2'd2} fwd_sel_t;

  typedef struct packed {
    logic [4:0] dest;
    logic       rs_used;
    logic       rt_used;
    tuse_t      tuse_rs;
    tuse_t      tuse_rt;
    tnew_t      tnew;
    logic       is_md;
    logic       is_hilo;
    logic       is_div;
    logic       is_store;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    d  = '0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV: begin
            d.dest    = instr[15:11];
            d.rs_used = 1'b1;
            d.rt_used = 1'b1;
            d.tuse_rs = TUSE_1;
            d.tuse_rt = TUSE_1;
            d.tnew    = TNEW_1;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            d.dest    = instr[15:11];
            d.rt_used = 1'b1;
            d.tuse_rt = TUSE_1;
            d.tnew    = TNEW_1;
          end
          FN_JR: begin
            d.rs_used = 1'b1;
            d.tuse_rs = TUSE_0;
          end
          FN_MFHI, FN_MFLO: begin
            d.dest    = instr[15:11];
            d.tnew    = TNEW_1;
            d.is_hilo = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            d.rs_used = 1'b1;
            d.tuse_rs = TUSE_1;
            d.is_hilo = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            d.rs_used = 1'b1;
            d.rt_used = 1'b1;
            d.tuse_rs = TUSE_1;
            d.tuse_rt = TUSE_1;
            d.is_md   = 1'b1;
            d.is_div  = (fn == FN_DIV) || (fn == FN_DIVU);
          end
          default: ;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        d.rs_used = 1'b1;
        d.rt_used = 1'b1;
        d.tuse_rs = TUSE_0;
        d.tuse_rt = TUSE_0;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        d.dest    = instr[20:16];
        d.rs_used = 1'b1;
        d.tuse_rs = TUSE_1;
        d.tnew    = TNEW_1;
      end
      OP_LUI: begin
        d.dest = instr[20:16];
        d.tnew = TNEW_1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        d.dest    = instr[20:16];
        d.rs_used = 1'b1;
        d.tuse_rs = TUSE_1;
        d.tnew    = TNEW_2;
      end
      OP_SB, OP_SH, OP_SW: begin
        d.rs_used  = 1'b1;
        d.rt_used  = 1'b1;
        d.tuse_rs  = TUSE_1;
        d.tuse_rt  = TUSE_2;
        d.is_store = 1'b1;
      end
      OP_JAL: begin
        d.dest = 5'd31;
        d.tnew = TNEW_0;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic tnew_t tnew_after(input tnew_t t);
    return (t == TNEW_2) ? TNEW_1 : TNEW_0;
  endfunction

  function automatic logic tnew_gt(input tnew_t tnew, input tuse_t tuse);
    logic [1:0] a;
    logic [1:0] b;
    a = tnew;
    b = tuse;
    return a > b;
  endfunction

  // $0 is hardwired, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] dest, input logic [4:0] src);
    return (dest != 5'd0) && (dest == src);
  endfunction

  function automatic fwd_sel_t fwd_pick(input logic used, input logic [4:0] src,
                                        input logic [4:0] m_dest, input tnew_t m_tnew,
                                        input logic [4:0] w_dest);
    if (!used) return FWD_RF;
    if (reg_hit(m_dest, src) && (m_tnew == TNEW_0)) return FWD_M;
    if (reg_hit(w_dest, src)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div unit busy countdown; busy covers the start cycle plus the loaded count.
module md_busy_timer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A start always reloads, even if a previous operation is still counting.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = start | (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: stalls, ID/EX flush,
// forwarding selects and MDU busy tracking. Optional HAZ_PERF_CNT_EN adds a stall counter.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  input  logic [31:0] instr_M,
  input  logic [31:0] instr_W,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_E,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        fwd_rt_M,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  dec_t       dec_d;
  dec_t       dec_e;
  dec_t       dec_m;
  dec_t       dec_w;
  tnew_t      tnew_m;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [4:0] rs_e;
  logic [4:0] rt_e;
  logic [4:0] rt_m;
  logic       stall_rs_d;
  logic       stall_rt_d;
  logic       stall_md;
  logic       stall;

  always_comb begin
    dec_d  = decode(instr_D);
    dec_e  = decode(instr_E);
    dec_m  = decode(instr_M);
    dec_w  = decode(instr_W);
    tnew_m = tnew_after(dec_m.tnew);
    rs_d   = instr_D[25:21];
    rt_d   = instr_D[20:16];
    rs_e   = instr_E[25:21];
    rt_e   = instr_E[20:16];
    rt_m   = instr_M[20:16];
  end

  md_busy_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk   (clk),
    .reset (reset),
    .start (dec_e.is_md),
    .is_div(dec_e.is_div),
    .busy  (md_busy)
  );

  // A D-stage source must wait if a producer in E or M cannot deliver before it is used.
  always_comb begin
    stall_rs_d = dec_d.rs_used &&
                 ((reg_hit(dec_e.dest, rs_d) && tnew_gt(dec_e.tnew, dec_d.tuse_rs)) ||
                  (reg_hit(dec_m.dest, rs_d) && tnew_gt(tnew_m, dec_d.tuse_rs)));
    stall_rt_d = dec_d.rt_used &&
                 ((reg_hit(dec_e.dest, rt_d) && tnew_gt(dec_e.tnew, dec_d.tuse_rt)) ||
                  (reg_hit(dec_m.dest, rt_d) && tnew_gt(tnew_m, dec_d.tuse_rt)));
    stall_md   = (dec_d.is_md | dec_d.is_hilo) & md_busy;
    stall      = (stall_rs_d | stall_rt_d | stall_md) & ~reset;
  end

  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_E = stall;

  always_comb begin
    fwd_rs_D = FWD_RF;
    fwd_rt_D = FWD_RF;
    fwd_rs_E = FWD_RF;
    fwd_rt_E = FWD_RF;
    fwd_rt_M = 1'b0;
    if (!reset) begin
      fwd_rs_D = fwd_pick(dec_d.rs_used, rs_d, dec_m.dest, tnew_m, dec_w.dest);
      fwd_rt_D = fwd_pick(dec_d.rt_used, rt_d, dec_m.dest, tnew_m, dec_w.dest);
      fwd_rs_E = fwd_pick(dec_e.rs_used, rs_e, dec_m.dest, tnew_m, dec_w.dest);
      fwd_rt_E = fwd_pick(dec_e.rt_used, rt_e, dec_m.dest, tnew_m, dec_w.dest);
      fwd_rt_M = dec_m.is_store & reg_hit(dec_w.dest, rt_m);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios, then random
// instruction mixes against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int K_NONE = 0, K_ALU3 = 1, K_SHIFT = 2, K_ALUI = 3, K_LUI = 4, K_LOAD = 5,
                 K_STORE = 6, K_BR = 7, K_JR = 8, K_JAL = 9, K_MFHL = 10, K_MTHL = 11,
                 K_MULT = 12, K_DIV = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D, instr_E, instr_M, instr_W;
  logic        stall_F, stall_D, flush_E, fwd_rt_M, md_busy;
  logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [31:0] stall_cnt;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M), .instr_W(instr_W),
    .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .fwd_rt_M(fwd_rt_M), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          busy_end = -1;
  logic [31:0] cnt_model = '0;
  bit          model_valid = 1'b0;
  bit          exp_stall, exp_busy, exp_start;
  int          start_len;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  localparam logic [31:0] NOP = 32'h0;

  // ---------------- reference model ----------------
  function automatic int kind_of(logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h21, 6'h23: return K_ALU3;
        6'h00:        return K_SHIFT;
        6'h08:        return K_JR;
        6'h10, 6'h12: return K_MFHL;
        6'h11, 6'h13: return K_MTHL;
        6'h18, 6'h19: return K_MULT;
        6'h1a, 6'h1b: return K_DIV;
        default:      return K_NONE;
      endcase
    end
    case (op)
      6'h04, 6'h05: return K_BR;
      6'h09, 6'h0d: return K_ALUI;
      6'h0f:        return K_LUI;
      6'h23:        return K_LOAD;
      6'h2b:        return K_STORE;
      6'h03:        return K_JAL;
      default:      return K_NONE;
    endcase
  endfunction

  function automatic int dest_of(logic [31:0] i);
    int k = kind_of(i);
    if (k == K_LOAD || k == K_ALUI || k == K_LUI) return int'(i[20:16]);
    if (k == K_ALU3 || k == K_SHIFT || k == K_MFHL) return int'(i[15:11]);
    if (k == K_JAL) return 31;
    return 0;
  endfunction

  function automatic int tnew_of(logic [31:0] i);
    int k = kind_of(i);
    if (k == K_LOAD) return 2;
    if (k == K_ALU3 || k == K_SHIFT || k == K_ALUI || k == K_LUI || k == K_MFHL) return 1;
    return 0;
  endfunction

  // -1 means the operand is not read.
  function automatic int tuse_rs_of(logic [31:0] i);
    int k = kind_of(i);
    if (k == K_BR || k == K_JR) return 0;
    if (k == K_ALU3 || k == K_ALUI || k == K_LOAD || k == K_STORE || k == K_MTHL ||
        k == K_MULT || k == K_DIV) return 1;
    return -1;
  endfunction

  function automatic int tuse_rt_of(logic [31:0] i);
    int k = kind_of(i);
    if (k == K_BR) return 0;
    if (k == K_ALU3 || k == K_SHIFT || k == K_MULT || k == K_DIV) return 1;
    if (k == K_STORE) return 2;
    return -1;
  endfunction

  function automatic bit src_stall(int r, int tu, logic [31:0] ie, logic [31:0] im);
    int tm;
    if (tu < 0 || r == 0) return 1'b0;
    tm = (tnew_of(im) > 0) ? tnew_of(im) - 1 : 0;
    return (dest_of(ie) == r && tnew_of(ie) > tu) || (dest_of(im) == r && tm > tu);
  endfunction

  function automatic logic [1:0] exp_fwd(int r, int tu, logic [31:0] im, logic [31:0] iw);
    int tm;
    if (tu < 0 || r == 0) return 2'd0;
    tm = (tnew_of(im) > 0) ? tnew_of(im) - 1 : 0;
    if (dest_of(im) == r && tm == 0) return 2'd1;
    if (dest_of(iw) == r) return 2'd2;
    return 2'd0;
  endfunction

  // ---------------- checking ----------------
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int          kd, ke;
    int          rs_d, rt_d, rs_e, rt_e, rt_m;
    logic [1:0]  f_rs_d, f_rt_d, f_rs_e, f_rt_e;
    bit          f_m;
    kd = kind_of(instr_D);
    ke = kind_of(instr_E);
    rs_d = int'(instr_D[25:21]); rt_d = int'(instr_D[20:16]);
    rs_e = int'(instr_E[25:21]); rt_e = int'(instr_E[20:16]);
    rt_m = int'(instr_M[20:16]);
    exp_start = (ke == K_MULT || ke == K_DIV);
    start_len = (ke == K_DIV) ? DIV_N : MULT_N;
    exp_busy  = exp_start || (cyc <= busy_end);
    exp_stall = !reset && (src_stall(rs_d, tuse_rs_of(instr_D), instr_E, instr_M) ||
                           src_stall(rt_d, tuse_rt_of(instr_D), instr_E, instr_M) ||
                           (exp_busy && (kd == K_MULT || kd == K_DIV || kd == K_MFHL || kd == K_MTHL)));
    f_rs_d = reset ? 2'd0 : exp_fwd(rs_d, tuse_rs_of(instr_D), instr_M, instr_W);
    f_rt_d = reset ? 2'd0 : exp_fwd(rt_d, tuse_rt_of(instr_D), instr_M, instr_W);
    f_rs_e = reset ? 2'd0 : exp_fwd(rs_e, tuse_rs_of(instr_E), instr_M, instr_W);
    f_rt_e = reset ? 2'd0 : exp_fwd(rt_e, tuse_rt_of(instr_E), instr_M, instr_W);
    f_m    = !reset && kind_of(instr_M) == K_STORE && rt_m != 0 && dest_of(instr_W) == rt_m;
    cmp("stall_F", 32'(stall_F), 32'(exp_stall));
    cmp("stall_D", 32'(stall_D), 32'(exp_stall));
    cmp("flush_E", 32'(flush_E), 32'(exp_stall));
    cmp("fwd_rs_D", 32'(fwd_rs_D), 32'(f_rs_d));
    cmp("fwd_rt_D", 32'(fwd_rt_D), 32'(f_rt_d));
    cmp("fwd_rs_E", 32'(fwd_rs_E), 32'(f_rs_e));
    cmp("fwd_rt_E", 32'(fwd_rt_E), 32'(f_rt_e));
    cmp("fwd_rt_M", 32'(fwd_rt_M), 32'(f_m));
    cmp("md_busy", 32'(md_busy), 32'(exp_busy));
    cmp("stall_cnt", stall_cnt, PERF ? cnt_model : 32'd0);
  endtask

  // Drive one cycle's inputs shortly after the rising edge and check mid-cycle.
  task automatic step(input bit rst, input logic [31:0] d, e, m, w);
    reset = rst; instr_D = d; instr_E = e; instr_M = m; instr_W = w;
    #2;
    if (model_valid) check_all();
  endtask

  task automatic tick();
    if (model_valid) begin
      if (reset) begin
        busy_end  = -1;
        cnt_model = '0;
      end else begin
        if (exp_start) busy_end = cyc + start_len - 1;
        if (exp_stall) cnt_model = cnt_model + 32'd1;
      end
    end else if (reset) begin
      model_valid = 1'b1;
      busy_end    = -1;
      cnt_model   = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rnd_instr(input bit allow_md);
    int k, a, b, c;
    k = $urandom_range(0, 18);
    a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
    if (!allow_md && (k == 16 || k == 17)) k = 1;
    case (k)
      0:  return NOP;
      1:  return enc_r(a, b, c, 0, 6'h21);
      2:  return enc_r(a, b, c, 0, 6'h23);
      3:  return enc_r(0, b, c, $urandom_range(0, 31), 6'h00);
      4:  return enc_i(6'h09, a, b, 16'($urandom));
      5:  return enc_i(6'h0d, a, b, 16'($urandom));
      6:  return enc_i(6'h0f, 0, b, 16'($urandom));
      7:  return enc_i(6'h23, a, b, 16'($urandom));
      8:  return enc_i(6'h2b, a, b, 16'($urandom));
      9:  return enc_i(6'h04, a, b, 16'($urandom));
      10: return enc_i(6'h05, a, b, 16'($urandom));
      11: return enc_r(a, 0, 0, 0, 6'h08);
      12: return {6'h03, 26'($urandom)};
      13: return enc_r(0, 0, c, 0, 6'h10);
      14: return enc_r(0, 0, c, 0, 6'h12);
      15: return enc_r(a, 0, 0, 0, 6'h11);
      16: return enc_r(a, b, 0, 0, 6'h18);
      17: return enc_r(a, b, 0, 0, 6'h1a);
      default: return {6'h02, 26'($urandom)};
    endcase
  endfunction

  logic [31:0] lw1, addu2, beq12, addu1, div12, mult12, mflo4, sw5, addu5w, sw0, addu0w;

  initial begin
    lw1    = enc_i(6'h23, 0, 1, 16'h0);
    addu2  = enc_r(1, 3, 2, 0, 6'h21);
    beq12  = enc_i(6'h04, 1, 2, 16'h4);
    addu1  = enc_r(2, 3, 1, 0, 6'h21);
    div12  = enc_r(1, 2, 0, 0, 6'h1a);
    mult12 = enc_r(1, 2, 0, 0, 6'h18);
    mflo4  = enc_r(0, 0, 4, 0, 6'h12);
    sw5    = enc_i(6'h2b, 0, 5, 16'h8);
    addu5w = enc_r(1, 2, 5, 0, 6'h21);
    sw0    = enc_i(6'h2b, 1, 0, 16'h0);
    addu0w = enc_r(1, 2, 0, 0, 6'h21);

    #1;
    step(1, NOP, NOP, NOP, NOP); tick();
    step(1, addu2, lw1, addu1, addu5w);
    cmp("rst_stall", 32'(stall_F), 32'd0);
    cmp("rst_fwd", 32'(fwd_rs_E), 32'd0);
    tick();

    // Load-use: lw in E, then in M with a branch, then in W feeding E.
    step(0, addu2, lw1, NOP, NOP);
    cmp("lw_E_stall", 32'(stall_D), 32'd1);
    cmp("lw_E_flush", 32'(flush_E), 32'd1);
    tick();
    step(0, beq12, NOP, lw1, NOP);
    cmp("lw_M_beq_stall", 32'(stall_F), 32'd1);
    tick();
    step(0, NOP, addu2, NOP, lw1);
    cmp("lw_W_fwd_rs_E", 32'(fwd_rs_E), 32'd2);
    tick();

    // ALU result feeding a branch from M and from E.
    step(0, beq12, NOP, addu1, NOP);
    cmp("alu_M_beq_stall", 32'(stall_F), 32'd0);
    cmp("alu_M_beq_fwd", 32'(fwd_rs_D), 32'd1);
    tick();
    step(0, beq12, addu1, NOP, NOP);
    cmp("alu_E_beq_stall", 32'(stall_F), 32'd1);
    tick();
    step(0, beq12, NOP, addu1, NOP);
    cmp("alu_E_beq_release", 32'(stall_F), 32'd0);
    tick();

    // Store data forwarding from W.
    step(0, NOP, NOP, sw5, addu5w);
    cmp("sw_fwd_rt_M", 32'(fwd_rt_M), 32'd1);
    tick();
    step(0, NOP, NOP, sw0, addu0w);
    cmp("sw_r0_fwd_rt_M", 32'(fwd_rt_M), 32'd0);
    tick();

    // div in E with mflo waiting: 10 stall cycles, then release.
    step(1, NOP, NOP, NOP, NOP); tick();
    step(0, mflo4, div12, NOP, NOP);
    cmp("div_stall_1", 32'(stall_D), 32'd1);
    tick();
    for (int i = 2; i <= DIV_N; i++) begin
      step(0, mflo4, NOP, NOP, NOP);
      cmp("div_stall_n", 32'(stall_D), 32'd1);
      tick();
    end
    step(0, mflo4, NOP, NOP, NOP);
    cmp("div_release", 32'(stall_D), 32'd0);
    cmp("div_busy_off", 32'(md_busy), 32'd0);
    cmp("div_stall_cnt", stall_cnt, PERF ? 32'd10 : 32'd0);
    tick();

    // mult: 5 stall cycles.
    step(0, mflo4, mult12, NOP, NOP); tick();
    for (int i = 2; i <= MULT_N; i++) begin
      step(0, mflo4, NOP, NOP, NOP);
      cmp("mult_stall_n", 32'(stall_D), 32'd1);
      tick();
    end
    step(0, mflo4, NOP, NOP, NOP);
    cmp("mult_release", 32'(stall_D), 32'd0);
    tick();

    // Reset while the timer reads 6 abandons the operation.
    step(0, NOP, div12, NOP, NOP); tick();
    for (int i = 0; i < 3; i++) begin
      step(0, NOP, NOP, NOP, NOP); tick();
    end
    step(1, NOP, NOP, NOP, NOP);
    cmp("rst_mid_busy_before", 32'(md_busy), 32'd1);
    tick();
    step(0, mflo4, NOP, NOP, NOP);
    cmp("rst_mid_busy_after", 32'(md_busy), 32'd0);
    cmp("rst_mid_stall", 32'(stall_D), 32'd0);
    cmp("rst_mid_cnt", stall_cnt, 32'd0);
    tick();

    // Random instruction mixes against the model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) == 0), rnd_instr(1'b1),
           rnd_instr($urandom_range(0, 9) == 0), rnd_instr(1'b0), rnd_instr(1'b0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
